// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern path: serializer state encoding
// and the word width common to the serializer and the detector bench.
package seq_pkg;

  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int SEQ_DATA_W = 8;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel-in handshake plus serial-out status bundle of the bit serializer.
// master = upstream word source / observer, slave = the serializer itself.
interface seq_bit_serializer_if
  import seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W
);

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              word_done;
  logic              busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  bit_out,
    input  bit_valid,
    input  word_done,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output bit_out,
    output bit_valid,
    output word_done,
    output busy
  );

endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the pattern detector: one word per valid/ready
// accept, one bit per clock, back-to-back words without an idle gap.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int DATA_W    = SEQ_DATA_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  seq_bit_serializer_if.slave  bus
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  ser_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              word_done_q, word_done_d;
  logic              last_bit_s;
  logic              accept_s;

  assign last_bit_s    = (cnt_q == LAST_CNT);
  assign bus.din_ready = rst_ni & ((state_q == SER_IDLE) | last_bit_s);
  assign accept_s      = bus.din_valid & bus.din_ready;

  // Next-state, shift datapath and output pre-computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = bit_valid_q;
    word_done_d = 1'b0;

    case (state_q)
      SER_IDLE: begin
        if (accept_s) begin
          state_d     = SER_SHIFT;
          cnt_d       = {CNT_W{1'b0}};
          bit_valid_d = 1'b1;
        end else begin
          bit_out_d   = IDLE_BIT;
          bit_valid_d = 1'b0;
        end
      end
      SER_SHIFT: begin
        if (!last_bit_s) begin
          cnt_d       = cnt_q + CNT_W'(1);
          bit_valid_d = 1'b1;
        end else if (accept_s) begin
          cnt_d       = {CNT_W{1'b0}};
          bit_valid_d = 1'b1;
        end else begin
          state_d     = SER_IDLE;
          cnt_d       = {CNT_W{1'b0}};
          bit_out_d   = IDLE_BIT;
          bit_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = SER_IDLE;
        cnt_d       = {CNT_W{1'b0}};
        shift_d     = {DATA_W{1'b0}};
        bit_out_d   = IDLE_BIT;
        bit_valid_d = 1'b0;
      end
    endcase

    // A fresh word loads on accept; otherwise a shifting word advances one bit.
    if (accept_s) begin
      if (MSB_FIRST) begin
        bit_out_d = bus.din[DATA_W-1];
        shift_d   = {bus.din[DATA_W-2:0], 1'b0};
      end else begin
        bit_out_d = bus.din[0];
        shift_d   = {1'b0, bus.din[DATA_W-1:1]};
      end
    end else if ((state_q == SER_SHIFT) && !last_bit_s) begin
      if (MSB_FIRST) begin
        bit_out_d = shift_q[DATA_W-1];
        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
      end else begin
        bit_out_d = shift_q[0];
        shift_d   = {1'b0, shift_q[DATA_W-1:1]};
      end
    end else begin
      shift_d = shift_d;
    end

    word_done_d = (state_d == SER_SHIFT) && (cnt_d == LAST_CNT);
  end

  // State, counter, shift register and registered serial outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SER_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      shift_q     <= {DATA_W{1'b0}};
      bit_out_q   <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.word_done = word_done_q;
  assign bus.busy      = (state_q == SER_SHIFT);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: an MSB-first and an LSB-first instance,
// expected bits queued at stimulus time and popped by per-instance monitors.
module tb_seq_bit_serializer;
  import seq_pkg::*;

  localparam int W = SEQ_DATA_W;

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_bit_serializer_if #(.DATA_W(W)) bus_a ();
  seq_bit_serializer_if #(.DATA_W(W)) bus_b ();

  seq_bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_a)
  );

  seq_bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   run_a = 0, last_run_a = 0, gap_a = 0, last_gap_a = 0;
  int   det_hits = 0;
  logic [4:0] det_sh = 5'b00000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Monitor A: pops expected bits, tracks run/gap lengths and a 10010 detector model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("busy_a", 32'(bus_a.busy), 32'(bus_a.bit_valid));
        det_sh = {det_sh[3:0], bus_a.bit_out};
        if (det_sh == 5'b10010) det_hits++;
        if (bus_a.bit_valid) begin
          if (gap_a > 0) last_gap_a = gap_a;
          gap_a = 0;
          run_a++;
          if (q_a.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_bit_a: got bit %0b expected none at %0t", bus_a.bit_out, $time);
          end else begin
            e = q_a.pop_front();
            check("bit_a", 32'(bus_a.bit_out), 32'(e.b));
            check("done_a", 32'(bus_a.word_done), 32'(e.d));
          end
        end else begin
          if (run_a > 0) last_run_a = run_a;
          run_a = 0;
          gap_a++;
          check("idle_bit_a", 32'(bus_a.bit_out), 32'd0);
          check("idle_done_a", 32'(bus_a.word_done), 32'd0);
        end
      end else begin
        run_a = 0;
        gap_a = 0;
      end
    end
  end

  // Monitor B: pops expected bits of the LSB-first instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("busy_b", 32'(bus_b.busy), 32'(bus_b.bit_valid));
        if (bus_b.bit_valid) begin
          if (q_b.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_bit_b: got bit %0b expected none at %0t", bus_b.bit_out, $time);
          end else begin
            e = q_b.pop_front();
            check("bit_b", 32'(bus_b.bit_out), 32'(e.b));
            check("done_b", 32'(bus_b.word_done), 32'(e.d));
          end
        end else begin
          check("idle_bit_b", 32'(bus_b.bit_out), 32'd0);
        end
      end
    end
  end

  task automatic push_a(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) q_a.push_back('{b: w[W-1-i], d: (i == W-1)});
  endtask

  // Drives a word on A and returns one tick into its first bit cycle.
  task automatic send_a(input logic [W-1:0] w, input int npush);
    int k;
    push_a(w, npush);
    bus_a.din       = w;
    bus_a.din_valid = 1'b1;
    k = 0;
    while (!bus_a.din_ready && k < 40) begin
      tick();
      k++;
    end
    check("accept_a", 32'(bus_a.din_ready), 32'd1);
    @(posedge clk);
    tick();
  endtask

  task automatic wait_done_a();
    int k;
    k = 0;
    while (!bus_a.word_done && k < 40) begin
      tick();
      k++;
    end
    check("word_done_seen_a", 32'(bus_a.word_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    int base;
    bus_a.din = '0; bus_a.din_valid = 1'b0;
    bus_b.din = '0; bus_b.din_valid = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready_a", 32'(bus_a.din_ready), 32'd0);
    check("rst_ready_b", 32'(bus_b.din_ready), 32'd0);
    check("rst_valid_a", 32'(bus_a.bit_valid), 32'd0);
    check("rst_bit_a", 32'(bus_a.bit_out), 32'd0);
    check("rst_done_a", 32'(bus_a.word_done), 32'd0);
    check("rst_busy_a", 32'(bus_a.busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready_a", 32'(bus_a.din_ready), 32'd1);
    tick();

    // 1: single word A5, MSB first
    send_a(8'hA5, 8);
    bus_a.din_valid = 1'b0;
    wait_done_a();
    tick();
    check("t1_idle_valid", 32'(bus_a.bit_valid), 32'd0);
    check("t1_idle_bit", 32'(bus_a.bit_out), 32'd0);
    check("t1_run_len", 32'(last_run_a), 32'd8);
    tick();

    // 2: back-to-back 12, 48
    send_a(8'h12, 8);
    send_a(8'h48, 8);
    bus_a.din_valid = 1'b0;
    wait_done_a();
    tick();
    check("t2_run_len", 32'(last_run_a), 32'd16);
    check("t2_idle_valid", 32'(bus_a.bit_valid), 32'd0);
    tick();

    // 6: three-cycle stall between words
    send_a(8'h3C, 8);
    bus_a.din_valid = 1'b0;
    wait_done_a();
    repeat (3) tick();
    send_a(8'hC3, 8);
    bus_a.din_valid = 1'b0;
    check("t6_gap_len", 32'(last_gap_a), 32'd3);
    wait_done_a();
    tick();
    tick();

    // 3: LSB first on B, din changes while not ready are ignored
    for (int i = 0; i < W; i++) q_b.push_back('{b: 1'(8'h01 >> i), d: (i == W-1)});
    bus_b.din       = 8'h01;
    bus_b.din_valid = 1'b1;
    check("t3_ready_idle", 32'(bus_b.din_ready), 32'd1);
    @(posedge clk);
    tick();
    for (int i = 1; i < W; i++) begin
      check("t3_ready_mid", 32'(bus_b.din_ready), 32'd0);
      bus_b.din = 8'hF0 ^ 8'(i);
      tick();
    end
    check("t3_ready_last", 32'(bus_b.din_ready), 32'd1);
    bus_b.din_valid = 1'b0;
    tick();
    check("t3_idle_valid", 32'(bus_b.bit_valid), 32'd0);

    // 5: detector integration, 92 gives two overlapping hits, 00 gives none
    base = det_hits;
    send_a(8'h92, 8);
    bus_a.din_valid = 1'b0;
    wait_done_a();
    repeat (3) tick();
    check("t5_det_92", 32'(det_hits - base), 32'd2);
    base = det_hits;
    send_a(8'h00, 8);
    bus_a.din_valid = 1'b0;
    wait_done_a();
    repeat (3) tick();
    check("t5_det_00", 32'(det_hits - base), 32'd0);

    // 4: reset during bit 4 of FF
    send_a(8'hFF, 4);
    bus_a.din_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", 32'(bus_a.bit_valid), 32'd0);
    check("t4_rst_bit", 32'(bus_a.bit_out), 32'd0);
    check("t4_rst_busy", 32'(bus_a.busy), 32'd0);
    check("t4_rst_ready", 32'(bus_a.din_ready), 32'd0);
    check("t4_queue_drained", 32'(q_a.size()), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("t4_ready_after", 32'(bus_a.din_ready), 32'd1);
    repeat (12) tick();
    check("t4_no_leftover", 32'(last_run_a), 32'd8);
    check("t4_still_idle", 32'(bus_a.bit_valid), 32'd0);

    repeat (3) tick();
    check("final_q_a", 32'(q_a.size()), 32'd0);
    check("final_q_b", 32'(q_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
